// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract unit. Carry ripples one WIDTH/STAGES-bit chunk per
// stage with a valid/ready handshake on both sides. Revision 1.0.
`default_nettype none

module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RSLT,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int C = WIDTH / STAGES;

  // Index k holds what enters stage k; index k+1 is what stage k registered.
  logic [WIDTH-1:0] a_s [STAGES];
  logic [WIDTH-1:0] b_s [STAGES];
  logic [WIDTH-1:0] r_s [STAGES+1];
  logic [STAGES:0]  c_s;
  logic [STAGES:0]  v_s;
  logic [STAGES:0]  adv;

  assign a_s[0] = A;
  assign b_s[0] = SUB ? ~B : B;
  assign r_s[0] = '0;
  assign c_s[0] = SUB;
  assign v_s[0] = IN_VALID;

  always_comb begin
    adv[STAGES] = OUT_READY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !v_s[k+1] || adv[k+1];
    end
  end

  assign IN_READY  = adv[0];
  assign OUT_VALID = v_s[STAGES];
  assign RSLT      = r_s[STAGES];
  assign COUT      = c_s[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [C:0]       sum_w;
    logic [WIDTH-1:0] r_d;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] r_q;

    assign sum_w = {1'b0, a_s[k][k*C +: C]} + {1'b0, b_s[k][k*C +: C]} + {{C{1'b0}}, c_s[k]};

    always_comb begin
      r_d = r_s[k];
      r_d[k*C +: C] = sum_w[C-1:0];
    end

    // Data only loads with a real beat so idle stages keep their last contents.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv[k]) begin
        v_q <= v_s[k];
        if (v_s[k]) begin
          c_q <= sum_w[C];
          r_q <= r_d;
        end
      end
    end

    assign v_s[k+1] = v_q;
    assign c_s[k+1] = c_q;
    assign r_s[k+1] = r_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k] && v_s[k]) begin
          a_q <= a_s[k];
          b_q <= b_s[k];
        end
      end

      assign a_s[k+1] = a_q;
      assign b_s[k+1] = b_q;
    end else begin : g_last
      logic ovf_d;
      logic zero_d;
      logic ovf_q;
      logic zero_q;

      assign ovf_d  = (a_s[k][WIDTH-1] == b_s[k][WIDTH-1]) && (r_d[WIDTH-1] != a_s[k][WIDTH-1]);
      assign zero_d = ~|r_d;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv[k] && v_s[k]) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end

      assign OVF  = ovf_q;
      assign ZERO = zero_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and random checks of pipe_adder (32/2 and 16/4) against a queue model.
`default_nettype none

module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv32, ir32, sub32, ov32, or32, c32, o32, z32;
  logic [31:0] a32, b32, r32;
  logic        iv16, ir16, sub16, ov16, or16, c16, o16, z16;
  logic [15:0] a16, b16, r16;

  pipe_adder #(.WIDTH(32), .STAGES(2)) dut32 (
    .CLK(clk), .RST(rst), .IN_VALID(iv32), .IN_READY(ir32), .A(a32), .B(b32), .SUB(sub32),
    .OUT_VALID(ov32), .OUT_READY(or32), .RSLT(r32), .COUT(c32), .OVF(o32), .ZERO(z32)
  );

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .CLK(clk), .RST(rst), .IN_VALID(iv16), .IN_READY(ir16), .A(a16), .B(b16), .SUB(sub16),
    .OUT_VALID(ov16), .OUT_READY(or16), .RSLT(r16), .COUT(c16), .OVF(o16), .ZERO(z16)
  );

  int          ncmp = 0;
  int          nfail = 0;
  int          emit32 = 0;
  int          e0, idx, stall, cyc;
  bit          acc32, acc16, seen;
  logic [63:0] q32[$];
  logic [63:0] q16[$];
  logic [63:0] hold;
  logic [31:0] ta[4];
  logic [31:0] tb[4];
  bit          ts[4];

  function automatic logic [63:0] pack(input logic [31:0] r, input bit c, input bit o, input bit z);
    return {29'b0, z, o, c, r};
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [63:0] ref_model(input int w, input longint unsigned a,
                                            input longint unsigned b, input bit sub);
    longint unsigned m, r;
    longint sa, sb, sr, smax, smin;
    bit c, o;
    m = (64'd1 << w) - 1;
    if (sub) begin
      r = (a - b) & m;
      c = (a >= b);
    end else begin
      r = (a + b) & m;
      c = ((a + b) > m);
    end
    sa = longint'(a);
    sb = longint'(b);
    if (((a >> (w - 1)) & 1) != 0) sa = sa - (longint'(1) << w);
    if (((b >> (w - 1)) & 1) != 0) sb = sb - (longint'(1) << w);
    sr   = sub ? sa - sb : sa + sb;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    o    = (sr > smax) || (sr < smin);
    return pack(32'(r), c, o, (r == 0));
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    #1;
    acc32 = iv32 && ir32;
    acc16 = iv16 && ir16;
    if (ov32 && or32) begin
      emit32++;
      if (q32.size() == 0) chk("sb32_extra", 64'(ov32), 64'd0);
      else chk("sb32", pack(r32, c32, o32, z32), q32.pop_front());
    end
    if (ov16 && or16) begin
      if (q16.size() == 0) chk("sb16_extra", 64'(ov16), 64'd0);
      else chk("sb16", pack({16'b0, r16}, c16, o16, z16), q16.pop_front());
    end
    if (acc32) q32.push_back(ref_model(32, a32, b32, sub32));
    if (acc16) q16.push_back(ref_model(16, a16, b16, sub16));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input bit s);
    iv32 = 1'b1; a32 = a; b32 = b; sub32 = s;
    tick();
    chk("send32_acc", 64'(acc32), 64'd1);
    iv32 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit s);
    iv16 = 1'b1; a16 = a; b16 = b; sub16 = s;
    tick();
    chk("send16_acc", 64'(acc16), 64'd1);
    iv16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    iv32 = 0; a32 = '0; b32 = '0; sub32 = 0; or32 = 1;
    iv16 = 0; a16 = '0; b16 = '0; sub16 = 0; or16 = 1;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ov32", 64'(ov32), 64'd0);
    chk("rst_out32", pack(r32, c32, o32, z32), 64'd0);
    chk("rst_ov16", 64'(ov16), 64'd0);
    chk("rst_out16", pack({16'b0, r16}, c16, o16, z16), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_ir32", 64'(ir32), 64'd1);
    chk("rst_ir16", 64'(ir16), 64'd1);
    @(negedge clk);

    // Basic add and latency
    send32(32'h0000_000A, 32'h0000_0005, 1'b0);
    chk("t1_lat0", 64'(ov32), 64'd0);
    tick();
    chk("t1_lat1", 64'(ov32), 64'd1);
    chk("t1_val", pack(r32, c32, o32, z32), pack(32'h0000_000F, 0, 0, 0));
    tick();
    chk("t1_bubble", 64'(ov32), 64'd0);

    // Carry, overflow, subtraction, back to back
    send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("t2_wrap", pack(r32, c32, o32, z32), pack(32'h0000_0000, 1, 0, 1));
    send32(32'h1234_5678, 32'h8765_4321, 1'b0);
    chk("t2_ovf", pack(r32, c32, o32, z32), pack(32'h8000_0000, 0, 1, 0));
    send32(32'h0000_0005, 32'h0000_000A, 1'b1);
    chk("t2_sum", pack(r32, c32, o32, z32), pack(32'h9999_9999, 0, 0, 0));
    send32(32'h8000_0000, 32'h0000_0001, 1'b1);
    chk("t3_borrow", pack(r32, c32, o32, z32), pack(32'hFFFF_FFFB, 0, 0, 0));
    tick();
    chk("t3_subovf", pack(r32, c32, o32, z32), pack(32'h7FFF_FFFF, 1, 1, 0));
    tick();
    chk("t3_empty", 64'(ov32), 64'd0);

    // Stream of 4 with a 3-cycle stall after the first result
    for (int i = 0; i < 4; i++) begin
      ta[i] = $urandom; tb[i] = $urandom; ts[i] = 1'($urandom_range(0, 1));
    end
    e0 = emit32; idx = 0; stall = 0; cyc = 0; seen = 0;
    while ((idx < 4 || q32.size() != 0) && cyc < 30) begin
      iv32 = (idx < 4);
      if (idx < 4) begin a32 = ta[idx]; b32 = tb[idx]; sub32 = ts[idx]; end
      if (ov32 && !seen) begin
        seen = 1; stall = 3; hold = pack(r32, c32, o32, z32);
      end
      or32 = (stall == 0);
      #1;
      if (stall > 0) begin
        chk("t4_hold", pack(r32, c32, o32, z32), hold);
        chk("t4_inrdy", 64'(ir32), 64'd0);
      end
      tick();
      if (acc32) idx++;
      if (stall > 0) stall--;
      cyc++;
    end
    iv32 = 0; or32 = 1;
    chk("t4_drain", 64'(idx == 4 && q32.size() == 0), 64'd1);
    chk("t4_count", 64'(emit32 - e0), 64'd4);

    // Asynchronous reset with beats in flight
    send32($urandom, $urandom, 1'b0);
    send32($urandom, $urandom, 1'b1);
    chk("t5_inflight", 64'(ov32), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_ov", 64'(ov32), 64'd0);
    chk("t5_rst_out", pack(r32, c32, o32, z32), 64'd0);
    #1 rst = 1'b0;
    q32.delete();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_stale", 64'(ov32), 64'd0);
    end
    send32(32'h0, 32'h0, 1'b0);
    tick();
    chk("t5_zero", pack(r32, c32, o32, z32), pack(32'h0, 0, 0, 1));
    tick();

    // 16-bit, 4-stage ripple and latency
    send16(16'hFFFF, 16'h0001, 1'b0);
    chk("t6_lat0", 64'(ov16), 64'd0);
    send16(16'hFFFF, 16'hFFFF, 1'b0);
    chk("t6_lat1", 64'(ov16), 64'd0);
    tick();
    chk("t6_lat2", 64'(ov16), 64'd0);
    tick();
    chk("t6_lat3", 64'(ov16), 64'd1);
    chk("t6_ripple", pack({16'b0, r16}, c16, o16, z16), pack(32'h0000, 1, 0, 1));
    tick();
    chk("t6_ffff", pack({16'b0, r16}, c16, o16, z16), pack(32'hFFFE, 1, 0, 0));
    tick();

    // Random traffic with random backpressure on both instances
    for (int i = 0; i < 300; i++) begin
      iv32 = ($urandom_range(0, 3) != 0); a32 = pick32(); b32 = pick32();
      sub32 = 1'($urandom_range(0, 1)); or32 = ($urandom_range(0, 3) != 0);
      iv16 = ($urandom_range(0, 3) != 0); a16 = 16'(pick32()); b16 = 16'(pick32());
      sub16 = 1'($urandom_range(0, 1)); or16 = ($urandom_range(0, 3) != 0);
      tick();
    end
    iv32 = 0; iv16 = 0; or32 = 1; or16 = 1;
    for (int i = 0; i < 10 && (q32.size() != 0 || q16.size() != 0); i++) tick();
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain16", 64'(q16.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
